// File: rtl/mc_control_fsm.sv
// Multi-cycle Moore control sequencer for the single-ALU MIPS-subset datapath.
// Optional feature: define MC_CTRL_BNE_EN to decode opcode 5 (bne) as an inverted-zero branch.
module mc_control_fsm #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             branch_ne,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             done,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_FETCH    = 4'd1;
  localparam logic [3:0] S_DECODE   = 4'd2;
  localparam logic [3:0] S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_RD   = 4'd4;
  localparam logic [3:0] S_MEM_WB   = 4'd5;
  localparam logic [3:0] S_MEM_WR   = 4'd6;
  localparam logic [3:0] S_R_EXEC   = 4'd7;
  localparam logic [3:0] S_R_WB     = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JUMP     = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [5:0] OP_R   = 6'd0;
  localparam logic [5:0] OP_J   = 6'd2;
  localparam logic [5:0] OP_BEQ = 6'd4;
  localparam logic [5:0] OP_LW  = 6'd35;
  localparam logic [5:0] OP_SW  = 6'd43;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE = 6'd5;
`endif

  logic [3:0]       state_q, state_d;
  logic [5:0]       opcode_q, opcode_d;
  logic             trap_q, trap_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Only the opcode field of the instruction word steers sequencing.
  logic unused_instr_bits;
  assign unused_instr_bits = ^instr[25:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opcode_q <= 6'd0;
      trap_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      trap_q   <= trap_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_IDLE:   if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          opcode_d = instr[31:26];
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode_q)
          OP_R:         state_d = S_R_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: state_d = (opcode_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_R_EXEC:   state_d = S_R_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP: state_d = run ? S_FETCH : S_IDLE;
      S_MEM_WR:   if (mem_ready) state_d = run ? S_FETCH : S_IDLE;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IDLE;
    endcase
    trap_d  = trap_q | (state_d == S_TRAP);
    count_d = done ? count_q + {{(CNT_W-1){1'b0}}, 1'b1} : count_q;
  end

  // Moore decode; mem_ready only qualifies the FETCH strobes and the store retire.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    branch_ne     = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    aluop         = 2'b00;
    pc_source     = 2'b00;
    done          = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE:   alu_src_b = 2'b11;
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        done       = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        done      = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        aluop     = 2'b10;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        done      = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        aluop         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        done          = 1'b1;
`ifdef MC_CTRL_BNE_EN
        branch_ne     = (opcode_q == OP_BNE);
`endif
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        done      = 1'b1;
      end
      default: ;
    endcase
  end

  assign state       = state_q;
  assign trap        = trap_q;
  assign instr_count = count_q;

endmodule
